// File: rtl/doodle_pkg.sv
// doodle_pkg -- shared types and default constants for the doodle physics block.
//   phys_state_t : physics FSM states (IDLE / RUN / DEAD)
//   GS_*         : encodings of the game_state input driven by game control
//   DEF_*        : default physics / timing constants used as parameter defaults
package doodle_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } phys_state_t;

  localparam logic [1:0] GS_IDLE = 2'd0;
  localparam logic [1:0] GS_RUN  = 2'd1;
  localparam logic [1:0] GS_DEAD = 2'd2;

  localparam int DEF_FPS         = 60;
  localparam int DEF_CLK         = 50_000_000;
  localparam int DEF_EARTH       = 480;
  localparam int DEF_SCREEN_W    = 640;
  localparam int DEF_DOODLE_H    = 70;
  localparam int DEF_START_X     = 290;
  localparam int DEF_START_Y     = 300;
  localparam int DEF_GRAVITY     = 1;
  localparam int DEF_JUMP_V      = -15;
  localparam int DEF_VMAX        = 15;
  localparam int DEF_SCROLL_LINE = 160;

  // Width of the frame divider value seen by the physics block.
  localparam int DEF_CNT_W = $clog2(DEF_CLK / DEF_FPS) + 1;

endpackage

// File: rtl/doodle_physics_if.sv
// doodle_physics_if -- bundle between game control / collision logic and physics.
//   master : drives fps_counter, delta_x, game_state, plat_hit; reads results
//   slave  : the physics block; reads control inputs, drives doodle_x, doodle_y,
//            vel_y, scroll_dy and the one-cycle upd strobe
interface doodle_physics_if
  import doodle_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);
  logic [CNT_W-1:0] fps_counter;
  logic signed [8:0] delta_x;
  logic [1:0] game_state;
  logic plat_hit;
  logic [9:0] doodle_x;
  logic [9:0] doodle_y;
  logic signed [7:0] vel_y;
  logic [9:0] scroll_dy;
  logic upd;

  modport master (
    output fps_counter, delta_x, game_state, plat_hit,
    input  doodle_x, doodle_y, vel_y, scroll_dy, upd
  );

  modport slave (
    input  fps_counter, delta_x, game_state, plat_hit,
    output doodle_x, doodle_y, vel_y, scroll_dy, upd
  );
endinterface

// File: rtl/doodle_wrap_x.sv
// doodle_wrap_x -- combinational horizontal step with wrap-around.
//   x     in  10     current sprite left edge (0 .. SCREEN_W-1)
//   dx    in  9 s    signed step, |dx| < SCREEN_W
//   x_out out 10     stepped position folded back into 0 .. SCREEN_W-1
module doodle_wrap_x
  import doodle_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W
) (
  input  logic [9:0]        x,
  input  logic signed [8:0] dx,
  output logic [9:0]        x_out
);
  localparam logic signed [10:0] W = 11'(SCREEN_W);

  logic signed [10:0] sum;
  logic signed [10:0] wrapped;

  assign sum = $signed({1'b0, x}) + $signed({{2{dx[8]}}, dx});

  // A single fold is enough because the step is always narrower than the screen.
  always_comb begin
    wrapped = sum;
    if (sum < 11'sd0) begin
      wrapped = sum + W;
    end else if (sum >= W) begin
      wrapped = sum - W;
    end
  end

  assign x_out = wrapped[9:0];
endmodule

// File: rtl/doodle_physics.sv
// doodle_physics -- per-frame doodle motion (gravity, bounce, wrap, floor/top bound).
//   clk        in   system clock
//   rst        in   synchronous active-low reset
//   bus.slave       fps_counter / delta_x / game_state / plat_hit in,
//                   doodle_x / doodle_y / vel_y / scroll_dy / upd out
// A frame tick is the cycle with fps_counter all ones. The tick edge updates
// vel_y, the following edge updates the position and pulses upd; ticks seen
// while either stage is pending are dropped.
// Build option: define DOODLE_SCROLL_EN to hold the sprite at SCROLL_LINE and
// report the overshoot on scroll_dy instead of stopping it at the top edge.
module doodle_physics
  import doodle_pkg::*;
#(
  parameter int FPS         = DEF_FPS,
  parameter int CLK         = DEF_CLK,
  parameter int EARTH       = DEF_EARTH,
  parameter int SCREEN_W    = DEF_SCREEN_W,
  parameter int DOODLE_H    = DEF_DOODLE_H,
  parameter int START_X     = DEF_START_X,
  parameter int START_Y     = DEF_START_Y,
  parameter int GRAVITY     = DEF_GRAVITY,
  parameter int JUMP_V      = DEF_JUMP_V,
  parameter int VMAX        = DEF_VMAX,
  parameter int SCROLL_LINE = DEF_SCROLL_LINE
) (
  input logic clk,
  input logic rst,
  doodle_physics_if.slave bus
);
`ifdef DOODLE_SCROLL_EN
  localparam bit SCROLL_ON = 1'b1;
`else
  localparam bit SCROLL_ON = 1'b0;
`endif

  localparam int CNT_W = $clog2(CLK / FPS) + 1;
  localparam logic signed [10:0] FLOOR_Y  = 11'(EARTH - DOODLE_H);
  localparam logic signed [10:0] SCROLL_Y = 11'(SCROLL_LINE);
  localparam logic signed [8:0]  VMAX_V   = 9'(VMAX);
  localparam logic signed [8:0]  GRAV_V   = 9'(GRAVITY);
  localparam logic signed [7:0]  JUMP_VEL = 8'(JUMP_V);

  phys_state_t state_reg, state_next;
  logic vel_done_reg;
  logic upd_reg;
  logic [9:0] x_reg, y_reg, scroll_reg;
  logic signed [7:0] vel_reg, vel_next;
  logic signed [8:0] dx_reg;

  logic tick, accept;
  logic signed [8:0] vel_inc;
  logic signed [10:0] y_sum;
  logic [9:0] x_next, y_next, scroll_next;
  logic vel_clr;

  assign tick   = (bus.fps_counter == {CNT_W{1'b1}});
  assign accept = tick && !vel_done_reg && !upd_reg;

  assign vel_inc = $signed({vel_reg[7], vel_reg}) + GRAV_V;

  // Stage 1: next FSM state and velocity from the game_state seen at the tick.
  always_comb begin
    state_next = state_reg;
    vel_next   = vel_reg;
    case (bus.game_state)
      GS_IDLE: begin
        state_next = IDLE;
        vel_next   = '0;
      end
      GS_RUN: begin
        state_next = RUN;
        if (state_reg == IDLE) begin
          vel_next = JUMP_VEL;  // launch frame skips gravity
        end else if (bus.plat_hit && vel_reg > 8'sd0) begin
          vel_next = JUMP_VEL;  // only a falling doodle bounces
        end else if (vel_inc > VMAX_V) begin
          vel_next = VMAX_V[7:0];
        end else begin
          vel_next = vel_inc[7:0];
        end
      end
      default: state_next = DEAD;  // velocity frozen
    endcase
  end

  doodle_wrap_x #(
    .SCREEN_W(SCREEN_W)
  ) u_wrap_x (
    .x    (x_reg),
    .dx   (dx_reg),
    .x_out(x_next)
  );

  // Stage 2: vertical step uses the velocity already committed by stage 1.
  assign y_sum = $signed({1'b0, y_reg}) + $signed({{3{vel_reg[7]}}, vel_reg});

  always_comb begin
    y_next      = y_sum[9:0];
    scroll_next = '0;
    vel_clr     = 1'b0;
    if (y_sum > FLOOR_Y) begin
      y_next = FLOOR_Y[9:0];  // rests on the floor, velocity kept
    end else if (SCROLL_ON && y_sum < SCROLL_Y) begin
      y_next      = SCROLL_Y[9:0];
      scroll_next = 10'(SCROLL_Y - y_sum);
    end else if (!SCROLL_ON && y_sum < 11'sd0) begin
      y_next  = '0;
      vel_clr = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      vel_done_reg <= 1'b0;
      upd_reg      <= 1'b0;
      x_reg        <= 10'(START_X);
      y_reg        <= 10'(START_Y);
      vel_reg      <= '0;
      scroll_reg   <= '0;
      dx_reg       <= '0;
    end else begin
      vel_done_reg <= 1'b0;
      upd_reg      <= 1'b0;
      if (accept) begin
        state_reg    <= state_next;
        vel_reg      <= vel_next;
        dx_reg       <= bus.delta_x;
        vel_done_reg <= 1'b1;
      end
      // accept and vel_done_reg are mutually exclusive, so vel_reg has one writer per cycle.
      if (vel_done_reg) begin
        upd_reg <= 1'b1;
        case (state_reg)
          IDLE: begin
            x_reg      <= 10'(START_X);
            y_reg      <= 10'(START_Y);
            scroll_reg <= '0;
          end
          RUN: begin
            x_reg      <= x_next;
            y_reg      <= y_next;
            scroll_reg <= scroll_next;
            if (vel_clr) begin
              vel_reg <= '0;
            end
          end
          default: scroll_reg <= '0;
        endcase
      end
    end
  end

  assign bus.doodle_x  = x_reg;
  assign bus.doodle_y  = y_reg;
  assign bus.vel_y     = vel_reg;
  assign bus.scroll_dy = SCROLL_ON ? scroll_reg : '0;
  assign bus.upd       = upd_reg;
endmodule

// File: tb/tb_doodle_physics.sv
// tb_doodle_physics -- randomized self-checking bench for doodle_physics.
// A frame-level reference model (plain integer arithmetic on x, y, vy) predicts
// each frame; the bench checks vel_y at T+1, position/scroll/upd at T+2 and the
// end of the upd pulse at T+3. Honours DOODLE_SCROLL_EN like the design.
module tb_doodle_physics;
  localparam int CNT_W     = 21;
  localparam int X0        = 290;
  localparam int Y0        = 300;
  localparam int W         = 640;
  localparam int FLOOR     = 480 - 70;
  localparam int JUMP      = -15;
  localparam int VCAP      = 15;
  localparam int LINE      = 160;
`ifdef DOODLE_SCROLL_EN
  localparam bit SCROLL = 1'b1;
`else
  localparam bit SCROLL = 1'b0;
`endif

  logic clk;
  logic rst;
  doodle_physics_if bus ();

  doodle_physics dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // model state: mode 0=idle 1=run 2=dead
  int m_mode, m_x, m_y, m_v, m_s;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_x = X0; m_y = Y0; m_v = 0; m_s = 0;
  endtask

  task automatic model_step(input int gs, input int dx, input bit hit, output int v1);
    int prev, yp;
    prev   = m_mode;
    m_mode = (gs == 0) ? 0 : (gs == 1) ? 1 : 2;
    m_s    = 0;
    if (m_mode == 0) begin
      m_v = 0; m_x = X0; m_y = Y0;
      v1  = 0;
    end else if (m_mode == 1) begin
      if (prev == 0) m_v = JUMP;
      else if (hit && m_v > 0) m_v = JUMP;
      else m_v = (m_v + 1 > VCAP) ? VCAP : m_v + 1;
      v1 = m_v;
      m_x = m_x + dx;
      if (m_x < 0) m_x += W;
      else if (m_x >= W) m_x -= W;
      yp = m_y + m_v;
      if (yp > FLOOR) m_y = FLOOR;
      else if (SCROLL && yp < LINE) begin m_y = LINE; m_s = LINE - yp; end
      else if (!SCROLL && yp < 0) begin m_y = 0; m_v = 0; end
      else m_y = yp;
    end else begin
      v1 = m_v;
    end
  endtask

  task automatic idle_gap();
    int gap;
    gap = $urandom_range(0, 3);
    repeat (gap) begin
      @(negedge clk);
      bus.fps_counter = CNT_W'($urandom_range(0, (1 << CNT_W) - 2));
    end
  endtask

  task automatic check_state(input string pfx);
    chk({pfx, "_x"}, int'(bus.doodle_x), m_x);
    chk({pfx, "_y"}, int'(bus.doodle_y), m_y);
    chk({pfx, "_vy"}, int'(bus.vel_y), m_v);
    chk({pfx, "_sdy"}, int'(bus.scroll_dy), m_s);
  endtask

  task automatic frame(input int gs, input int dx, input bit hit);
    int v1;
    idle_gap();
    @(negedge clk);  // cycle T
    bus.game_state  = 2'(gs);
    bus.delta_x     = 9'(dx);
    bus.plat_hit    = hit;
    bus.fps_counter = '1;
    model_step(gs, dx, hit, v1);
    @(negedge clk);  // T+1; holding all ones here checks the busy drop
    if ($urandom_range(0, 1) == 0) bus.fps_counter = '0;
    chk("vy_t1", int'(bus.vel_y), v1);
    chk("upd_t1", int'(bus.upd), 0);
    @(negedge clk);  // T+2
    check_state("t2");
    chk("upd_t2", int'(bus.upd), 1);
    @(negedge clk);  // T+3
    bus.fps_counter = '0;
    chk("upd_t3", int'(bus.upd), 0);
    $display("frame gs=%0d dx=%0d hit=%0d -> x=%0d y=%0d vy=%0d sdy=%0d",
             gs, dx, hit, m_x, m_y, m_v, m_s);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.fps_counter = '1;
    repeat (3) @(negedge clk);
    model_reset();
    check_state("rst");
    chk("rst_upd", int'(bus.upd), 0);
    rst = 1'b1;
    bus.fps_counter = '0;
    $display("reset -> x=%0d y=%0d vy=0 sdy=0", X0, Y0);
  endtask

  // Reset asserted in T+1 must abort the frame before any upd pulse.
  task automatic reset_mid_frame(input int gs, input int dx);
    idle_gap();
    @(negedge clk);
    bus.game_state  = 2'(gs);
    bus.delta_x     = 9'(dx);
    bus.plat_hit    = 1'b0;
    bus.fps_counter = '1;
    @(negedge clk);
    rst = 1'b0;
    bus.fps_counter = '0;
    @(negedge clk);
    model_reset();
    chk("abort_upd", int'(bus.upd), 0);
    check_state("abort");
    rst = 1'b1;
    $display("mid-frame reset gs=%0d -> outputs at reset values", gs);
  endtask

  initial begin
    int gs, dx, guard;
    bit hit;
    rst = 1'b0;
    bus.fps_counter = '0;
    bus.delta_x     = '0;
    bus.game_state  = 2'd0;
    bus.plat_hit    = 1'b0;
    model_reset();

    do_reset();

    // launch from idle
    frame(1, 0, 0);
    chk("launch_y", int'(bus.doodle_y), Y0 + JUMP);

    // horizontal wrap at both edges
    frame(1, 255, 0);
    frame(1, 85, 0);
    chk("x_at_630", int'(bus.doodle_x), 630);
    frame(1, 15, 0);
    chk("wrap_hi", int'(bus.doodle_x), 5);
    frame(1, -2, 0);
    frame(1, -5, 0);
    chk("wrap_lo", int'(bus.doodle_x), 638);

    // fall to the floor, then bounce
    guard = 0;
    while (!(m_y == FLOOR && m_v == VCAP) && guard < 80) begin
      frame(1, 0, 0);
      guard++;
    end
    chk("reach_floor", (m_y == FLOOR && m_v == VCAP) ? 1 : 0, 1);
    frame(1, 0, 1);
    chk("bounce_vy", int'(bus.vel_y), JUMP);
    chk("bounce_y", int'(bus.doodle_y), FLOOR + JUMP);
    // plat_hit while rising must be ignored
    repeat (14) frame(1, 0, 1);

    // idle / dead handling
    frame(2, 40, 1);
    frame(2, 40, 0);
    frame(0, 0, 0);
    frame(2, 0, 0);
    frame(0, 0, 0);

    reset_mid_frame(1, 10);
    frame(1, 7, 0);  // first tick after release handled normally

    // randomized frames
    for (int i = 0; i < 400; i++) begin
      int r;
      r  = $urandom_range(0, 99);
      gs = (r < 4) ? 0 : (r < 8) ? 2 + $urandom_range(0, 1) : 1;
      if (m_mode == 2 && gs == 1) gs = ($urandom_range(0, 3) == 0) ? 0 : 2;
      dx  = $urandom_range(0, 510) - 255;
      hit = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 99) < 2) reset_mid_frame(gs, dx);
      else frame(gs, dx, hit);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/doodle_physics.md
DOODLE_PHYSICS -- requirements
Module: doodle_physics

Interface
REQ-001 Parameters (name, default, meaning) SHALL be as listed in REQ-002..REQ-011.
REQ-002 FPS, 60, frame rate.
REQ-003 CLK, 50_000_000, clock frequency in Hz.
REQ-004 EARTH, 480, floor line in pixels.
REQ-005 SCREEN_W, 640, horizontal playfield width.
REQ-006 DOODLE_H, 70, sprite height.
REQ-007 START_X, 290, spawn x.
REQ-008 START_Y, 300, spawn y.
REQ-009 GRAVITY, 1, per-frame vy increment.
REQ-010 JUMP_V, -15, launch/bounce velocity (signed).
REQ-011 VMAX, 15, fall-speed saturation; SCROLL_LINE, 160, scroll threshold.
REQ-012 Ports (name, direction, width, meaning) SHALL be: clk in 1, system clock; rst in 1, reset, synchronous, active-low; fps_counter in $clog2(CLK/FPS)+1, frame divider value; delta_x in 9 signed, per-frame horizontal step from control; game_state in 2, 0=idle/1=run/2=dead; plat_hit in 1, collision detector reports doodle feet on a platform; doodle_x out 10, sprite left edge; doodle_y out 10, sprite top edge, consumed by control; vel_y out 8 signed, current vertical velocity; scroll_dy out 10, per-frame camera shift; upd out 1, one-cycle pulse when outputs are updated.

Function
REQ-013 Frame tick SHALL be the cycle in which fps_counter is all ones (T).
REQ-014 Update pipeline: cycle T+1 registers vel_y; cycle T+2 registers doodle_x, doodle_y, scroll_dy and asserts upd for exactly one cycle.
REQ-015 Ticks arriving while the pipeline is busy (T+1, T+2) SHALL be ignored.
REQ-016 Internal FSM states SHALL be IDLE, RUN, DEAD; the tick that sees game_state==0 enters IDLE, 1 enters RUN, 2 or 3 enters DEAD.
REQ-017 IDLE: on each tick, x=START_X, y=START_Y, vel_y=0, scroll_dy=0.
REQ-018 IDLE->RUN tick: vel_y=JUMP_V (launch); gravity is not applied on that frame.
REQ-019 RUN velocity: if plat_hit and vel_y>0, vel_y=JUMP_V; else vel_y=min(vel_y+GRAVITY, VMAX); plat_hit with vel_y<=0 is ignored.
REQ-020 RUN position SHALL use the vel_y registered at T+1 (semi-implicit Euler).
REQ-021 Horizontal: x'=x+delta_x in 11-bit signed; if x'<0, add SCREEN_W; if x'>=SCREEN_W, subtract SCREEN_W; |delta_x|<SCREEN_W is guaranteed.
REQ-022 Vertical: y'=y+vel_y in 11-bit signed; if y'>EARTH-DOODLE_H, clamp to EARTH-DOODLE_H and keep vel_y.
REQ-023 Upward bound (SCROLL_EN absent): if y'<0, y=0 and vel_y=0.
REQ-024 DEAD: x, y, vel_y frozen; scroll_dy=0; upd still pulses each frame.

Reset
REQ-025 With rst low at a clock edge: doodle_x=START_X, doodle_y=START_Y, vel_y=0, scroll_dy=0, upd=0, FSM=IDLE, and any in-flight pipeline stage is aborted.
REQ-026 The first tick after rst is released SHALL be processed normally.

Configuration
REQ-027 Macro DOODLE_SCROLL_EN defined: if y'<SCROLL_LINE in RUN, y=SCROLL_LINE and scroll_dy=SCROLL_LINE-y'; otherwise scroll_dy=0; vel_y is unchanged.
REQ-028 Macro DOODLE_SCROLL_EN undefined: REQ-023 applies and scroll_dy is tied to 0.

Structure
REQ-029 Package doodle_pkg SHALL hold phys_state_t (IDLE/RUN/DEAD), the game_state encodings, and the default physics constants.
REQ-030 Horizontal wrap SHALL be a sub-module doodle_wrap_x (combinational, SCREEN_W parameter), instantiated once.

Verification
REQ-031 Reset -> x=290, y=300, vel_y=0, scroll_dy=0, upd=0.
REQ-032 game_state 0->1 at tick T -> vel_y=-15 at T+1; y=285 and upd=1 at T+2; upd=0 at T+3.
REQ-033 x=630, delta_x=+15 -> x=5; x=3, delta_x=-5 -> x=638.
REQ-034 y=400, vel_y=14, plat_hit=0 -> vel_y=15, y=410 (clamped); next tick with plat_hit=1 -> vel_y=-15, y=395; plat_hit=1 while vel_y=-3 -> vel_y=-2.
REQ-035 DOODLE_SCROLL_EN, y=165, vel_y=-10 (after gravity) -> y=160, scroll_dy=5; without the macro, y=155, scroll_dy=0.
REQ-036 rst low at T+1 -> no upd pulse, all outputs at reset values at T+2.
